multicycle_controller: RTL and testbench

- Moore FSM controller for the multicycle variant of the RV32I core.
- Sequences one shared ALU, one unified instruction/data memory and the architectural registers (PC, OldPC, IR, ALUOut, Data) across several cycles per instruction.
- Drives all datapath enables and mux selects, and honours a memory ready handshake.
- ALU control decode is inline; encodings match the single-cycle controller.

---
 rtl/multicycle_controller.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style control FSM for the multicycle RV32I core. A single ALU, one
// unified instruction/data memory and the architectural registers (PC,
// OldPC, IR, ALUOut, Data) are shared across several cycles per instruction.
// This block sequences them by driving every datapath enable and mux select.
//
// Parameters:
//   WAIT_MEM    1 = FETCH/MEMREAD/MEMWRITE stall until mem_ready
//               0 = mem_ready is ignored and treated as always ready
//
// Ports:
//   clk           in   1  system clock, rising edge
//   reset         in   1  synchronous, active-high
//   opcode        in   7  IR[6:0]
//   funct3        in   3  IR[14:12]
//   funct7bit5    in   1  IR[30]
//   Zero          in   1  ALU result == 0
//   ALUbit31      in   1  ALU result MSB
//   mem_ready     in   1  memory access completes this cycle
//   PCWrite       out  1  load PC from Result
//   AdrSrc        out  1  memory address: 0 = PC, 1 = Result
//   MemWrite      out  1  memory write strobe
//   IRWrite       out  1  load IR and OldPC
//   ResultSrc     out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUSrcA       out  2  00 = PC, 01 = OldPC, 10 = rs1
//   ALUSrcB       out  2  00 = rs2, 01 = ImmExt, 10 = constant 4
//   ImmSrc        out  2  00 = I, 01 = S, 10 = B, 11 = J
//   RegWrite      out  1  register file write enable
//   ALUControl    out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//   state         out  4  current state, for debug
//   illegal_instr out  1  one-cycle pulse in DECODE for an unsupported opcode
// ---------------------------------------------------------------------------
module multicycle_controller #(
   parameter bit WAIT_MEM = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7bit5,
   input  logic       Zero,
   input  logic       ALUbit31,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic [2:0] ALUControl,
   output logic [3:0] state,
   output logic       illegal_instr
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALR     = 4'd11,
      JALRWB   = 4'd12
   } stateT;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluOpT;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   stateT currentState;
   stateT nextState;
   aluOpT aluOp;

   logic memReady;
   logic branchTaken;
   logic pcWriteRaw;
   logic irWriteRaw;
   logic memWriteRaw;
   logic regWriteRaw;

   // With WAIT_MEM cleared the memory is assumed to answer in one cycle, so
   // the handshake collapses to a constant and the stall arcs disappear.
   assign memReady = WAIT_MEM ? mem_ready : 1'b1;

   assign state = currentState;

   // State register. Reset is sampled on the clock edge and always lands in
   // FETCH, abandoning whatever instruction was in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         currentState <= FETCH;
      end else begin
         currentState <= nextState;
      end
   end

   // Next-state logic. The memory states hold until the handshake completes;
   // DECODE fans out on the opcode, and anything unrecognised (including the
   // three unused state codes) falls back to FETCH.
   always_comb begin
      nextState = FETCH;
      case (currentState)
         FETCH:    nextState = memReady ? DECODE : FETCH;
         DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: nextState = MEMADR;
               OP_RTYPE:          nextState = EXECUTER;
               OP_ITYPE:          nextState = EXECUTEI;
               OP_BRANCH:         nextState = BRANCH;
               OP_JAL:            nextState = JAL;
               OP_JALR:           nextState = JALR;
               default:           nextState = FETCH;
            endcase
         end
         MEMADR:   nextState = opcode[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  nextState = memReady ? MEMWB : MEMREAD;
         MEMWB:    nextState = FETCH;
         MEMWRITE: nextState = memReady ? FETCH : MEMWRITE;
         EXECUTER: nextState = ALUWB;
         EXECUTEI: nextState = ALUWB;
         ALUWB:    nextState = FETCH;
         BRANCH:   nextState = FETCH;
         JAL:      nextState = ALUWB;
         JALR:     nextState = JALRWB;
         JALRWB:   nextState = FETCH;
         default:  nextState = FETCH;
      endcase
   end

   // Branch decision from the flags of rs1 - rs2. Only the signed-looking
   // beq/bne/blt/bge encodings are honoured, using the raw MSB without any
   // overflow correction; the unsigned compares are never taken.
   always_comb begin
      branchTaken = 1'b0;
      case (funct3)
         3'b000:  branchTaken = Zero;
         3'b001:  branchTaken = ~Zero;
         3'b100:  branchTaken = ALUbit31;
         3'b101:  branchTaken = ~ALUbit31;
         default: branchTaken = 1'b0;
      endcase
   end

   // Per-state datapath controls. Everything defaults to zero so each state
   // only lists the fields it actually uses. The write strobes are produced
   // here in raw form and gated by reset further down.
   always_comb begin
      pcWriteRaw    = 1'b0;
      irWriteRaw    = 1'b0;
      memWriteRaw   = 1'b0;
      regWriteRaw   = 1'b0;
      AdrSrc        = 1'b0;
      ResultSrc     = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      aluOp         = ALUOP_ADD;
      illegal_instr = 1'b0;
      case (currentState)
         FETCH: begin
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            irWriteRaw = memReady;
            pcWriteRaw = memReady;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (opcode)
               OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
               OP_BRANCH, OP_JAL, OP_JALR: illegal_instr = 1'b0;
               default:                    illegal_instr = 1'b1;
            endcase
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
         end
         MEMWB: begin
            ResultSrc   = 2'b01;
            regWriteRaw = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc      = 1'b1;
            memWriteRaw = 1'b1;
         end
         EXECUTER: begin
            ALUSrcA = 2'b10;
            aluOp   = ALUOP_FUNCT;
         end
         EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            aluOp   = ALUOP_FUNCT;
         end
         ALUWB: begin
            regWriteRaw = 1'b1;
         end
         BRANCH: begin
            ALUSrcA    = 2'b10;
            aluOp      = ALUOP_SUB;
            pcWriteRaw = branchTaken;
         end
         JAL: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            pcWriteRaw = 1'b1;
         end
         JALR: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ResultSrc  = 2'b10;
            pcWriteRaw = 1'b1;
         end
         JALRWB: begin
            ALUSrcA     = 2'b01;
            ALUSrcB     = 2'b10;
            ResultSrc   = 2'b10;
            regWriteRaw = 1'b1;
         end
         default: begin
            pcWriteRaw = 1'b0;
         end
      endcase
   end

   // No architectural state may change in a reset cycle, even though the
   // state register still shows the abandoned state until the next edge.
   assign PCWrite  = pcWriteRaw  & ~reset;
   assign IRWrite  = irWriteRaw  & ~reset;
   assign MemWrite = memWriteRaw & ~reset;
   assign RegWrite = regWriteRaw & ~reset;

   // ALU control decode. Subtract for R-type funct3=000 needs both the
   // register form (opcode[5]) and funct7 bit 5, so addi with a stray
   // IR[30] still adds.
   always_comb begin
      ALUControl = 3'b000;
      case (aluOp)
         ALUOP_ADD: ALUControl = 3'b000;
         ALUOP_SUB: ALUControl = 3'b001;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  ALUControl = (opcode[5] & funct7bit5) ? 3'b001 : 3'b000;
               3'b010:  ALUControl = 3'b101;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default:   ALUControl = 3'b000;
      endcase
   end

   // Immediate format follows the opcode in every state so the extender
   // output is already settled when DECODE computes the branch/jal target.
   always_comb begin
      ImmSrc = 2'b00;
      case (opcode)
         OP_STORE:  ImmSrc = 2'b01;
         OP_BRANCH: ImmSrc = 2'b10;
         OP_JAL:    ImmSrc = 2'b11;
         default:   ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. Each cycle the stimulus process
// drives the instruction fields and handshake, then queues the hand-derived
// output vector for that cycle. A separate monitor samples the DUT on the
// falling edge and compares against the head of the queue.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   typedef struct {
      logic [20:0] expv;
      string       name;
   } scoreEntryT;

   logic       clk;
   logic       reset;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7bit5;
   logic       Zero;
   logic       ALUbit31;
   logic       mem_ready;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic       RegWrite;
   logic [2:0] ALUControl;
   logic [3:0] state;
   logic       illegal_instr;

   scoreEntryT scoreboard[$];
   int         checks;
   int         errors;

   multicycle_controller #(.WAIT_MEM(1'b1)) dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .funct3        (funct3),
      .funct7bit5    (funct7bit5),
      .Zero          (Zero),
      .ALUbit31      (ALUbit31),
      .mem_ready     (mem_ready),
      .PCWrite       (PCWrite),
      .AdrSrc        (AdrSrc),
      .MemWrite      (MemWrite),
      .IRWrite       (IRWrite),
      .ResultSrc     (ResultSrc),
      .ALUSrcA       (ALUSrcA),
      .ALUSrcB       (ALUSrcB),
      .ImmSrc        (ImmSrc),
      .RegWrite      (RegWrite),
      .ALUControl    (ALUControl),
      .state         (state),
      .illegal_instr (illegal_instr)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Packs one expected output vector in the same field order the monitor
   // uses for the DUT outputs.
   function automatic logic [20:0] ev(input logic [3:0] st, input logic pcw,
                                      input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] imm, input logic rw,
                                      input logic [2:0] alu, input logic ill);
      return {st, pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu, ill};
   endfunction

   // FETCH: PC+4 on the ALU, strobes follow the memory handshake.
   function automatic logic [20:0] fetchV(input logic [1:0] imm, input logic rdy);
      return ev(4'd0, rdy, 1'b0, 1'b0, rdy, 2'b10, 2'b00, 2'b10, imm, 1'b0, 3'b000, 1'b0);
   endfunction

   // DECODE: OldPC + ImmExt for the branch/jal target.
   function automatic logic [20:0] decodeV(input logic [1:0] imm, input logic ill);
      return ev(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 1'b0, 3'b000, ill);
   endfunction

   // Drives one cycle of inputs, queues that cycle's expected outputs and
   // advances to just after the next rising edge.
   task automatic applyStimulus(input logic r, input logic [6:0] op,
                                input logic [2:0] f3, input logic f7,
                                input logic z, input logic b31, input logic rdy,
                                input logic [20:0] expv, input string name);
      scoreEntryT e;
      reset      = r;
      opcode     = op;
      funct3     = f3;
      funct7bit5 = f7;
      Zero       = z;
      ALUbit31   = b31;
      mem_ready  = rdy;
      e.expv     = expv;
      e.name     = name;
      scoreboard.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Compares the sampled DUT outputs with one scoreboard entry.
   task automatic checkOutput(input scoreEntryT e);
      logic [20:0] act;
      act = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, RegWrite, ALUControl, illegal_instr};
      checks++;
      if (act !== e.expv) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (state got %0d expected %0d)",
                  e.name, act, e.expv, act[20:17], e.expv[20:17]);
      end
   endtask

   // Monitor: every falling edge with a pending expectation is an output
   // presentation to check.
   initial begin
      forever begin
         @(negedge clk);
         if (scoreboard.size() > 0) begin
            checkOutput(scoreboard.pop_front());
         end
      end
   end

   // Stimulus program.
   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      opcode     = OP_LW;
      funct3     = 3'b010;
      funct7bit5 = 1'b0;
      Zero       = 1'b0;
      ALUbit31   = 1'b0;
      mem_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Still in reset: FETCH decode visible, strobes suppressed.
      applyStimulus(1, OP_LW, 3'b010, 0, 0, 0, 1, fetchV(2'b00, 1'b0), "reset");

      // lw, memory always ready: 0,1,2,3,4.
      applyStimulus(0, OP_LW, 3'b010, 0, 0, 0, 1, fetchV(2'b00, 1'b1), "lw_fetch");
      applyStimulus(0, OP_LW, 3'b010, 0, 0, 0, 1, decodeV(2'b00, 1'b0), "lw_decode");
      applyStimulus(0, OP_LW, 3'b010, 0, 0, 0, 1,
                    ev(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000, 0), "lw_memadr");
      applyStimulus(0, OP_LW, 3'b010, 0, 0, 0, 1,
                    ev(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0), "lw_memread");
      applyStimulus(0, OP_LW, 3'b010, 0, 0, 0, 1,
                    ev(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0), "lw_memwb");

      // lw with one wait cycle in MEMREAD.
      applyStimulus(0, OP_LW, 3'b010, 0, 0, 0, 1, fetchV(2'b00, 1'b1), "lw2_fetch");
      applyStimulus(0, OP_LW, 3'b010, 0, 0, 0, 1, decodeV(2'b00, 1'b0), "lw2_decode");
      applyStimulus(0, OP_LW, 3'b010, 0, 0, 0, 1,
                    ev(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000, 0), "lw2_memadr");
      applyStimulus(0, OP_LW, 3'b010, 0, 0, 0, 0,
                    ev(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0), "lw2_memread_wait");
      applyStimulus(0, OP_LW, 3'b010, 0, 0, 0, 1,
                    ev(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0), "lw2_memread_done");
      applyStimulus(0, OP_LW, 3'b010, 0, 0, 0, 1,
                    ev(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0), "lw2_memwb");

      // sub with two stall cycles in FETCH.
      applyStimulus(0, OP_R, 3'b000, 1, 0, 0, 0, fetchV(2'b00, 1'b0), "sub_fetch_wait1");
      applyStimulus(0, OP_R, 3'b000, 1, 0, 0, 0, fetchV(2'b00, 1'b0), "sub_fetch_wait2");
      applyStimulus(0, OP_R, 3'b000, 1, 0, 0, 1, fetchV(2'b00, 1'b1), "sub_fetch_ready");
      applyStimulus(0, OP_R, 3'b000, 1, 0, 0, 1, decodeV(2'b00, 1'b0), "sub_decode");
      applyStimulus(0, OP_R, 3'b000, 1, 0, 0, 1,
                    ev(4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b001, 0), "sub_executer");
      applyStimulus(0, OP_R, 3'b000, 1, 0, 0, 1,
                    ev(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0), "sub_aluwb");

      // slt: funct3 010 -> 101.
      applyStimulus(0, OP_R, 3'b010, 0, 0, 0, 1, fetchV(2'b00, 1'b1), "slt_fetch");
      applyStimulus(0, OP_R, 3'b010, 0, 0, 0, 1, decodeV(2'b00, 1'b0), "slt_decode");
      applyStimulus(0, OP_R, 3'b010, 0, 0, 0, 1,
                    ev(4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b101, 0), "slt_executer");
      applyStimulus(0, OP_R, 3'b010, 0, 0, 0, 1,
                    ev(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0), "slt_aluwb");

      // addi with IR[30]=1 still adds (opcode[5]=0).
      applyStimulus(0, OP_I, 3'b000, 1, 0, 0, 1, fetchV(2'b00, 1'b1), "addi_fetch");
      applyStimulus(0, OP_I, 3'b000, 1, 0, 0, 1, decodeV(2'b00, 1'b0), "addi_decode");
      applyStimulus(0, OP_I, 3'b000, 1, 0, 0, 1,
                    ev(4'd7, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b000, 0), "addi_executei");
      applyStimulus(0, OP_I, 3'b000, 1, 0, 0, 1,
                    ev(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0), "addi_aluwb");

      // andi: funct3 111 -> 010.
      applyStimulus(0, OP_I, 3'b111, 0, 0, 0, 1, fetchV(2'b00, 1'b1), "andi_fetch");
      applyStimulus(0, OP_I, 3'b111, 0, 0, 0, 1, decodeV(2'b00, 1'b0), "andi_decode");
      applyStimulus(0, OP_I, 3'b111, 0, 0, 0, 1,
                    ev(4'd7, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 3'b010, 0), "andi_executei");
      applyStimulus(0, OP_I, 3'b111, 0, 0, 0, 1,
                    ev(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0), "andi_aluwb");

      // beq with Zero=1: taken.
      applyStimulus(0, OP_B, 3'b000, 0, 1, 0, 1, fetchV(2'b10, 1'b1), "beq_fetch");
      applyStimulus(0, OP_B, 3'b000, 0, 1, 0, 1, decodeV(2'b10, 1'b0), "beq_decode");
      applyStimulus(0, OP_B, 3'b000, 0, 1, 0, 1,
                    ev(4'd9, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001, 0), "beq_branch_taken");

      // bne with Zero=1: not taken.
      applyStimulus(0, OP_B, 3'b001, 0, 1, 0, 1, fetchV(2'b10, 1'b1), "bne_fetch");
      applyStimulus(0, OP_B, 3'b001, 0, 1, 0, 1, decodeV(2'b10, 1'b0), "bne_decode");
      applyStimulus(0, OP_B, 3'b001, 0, 1, 0, 1,
                    ev(4'd9, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001, 0), "bne_branch_not_taken");

      // blt with ALUbit31=1: taken.
      applyStimulus(0, OP_B, 3'b100, 0, 0, 1, 1, fetchV(2'b10, 1'b1), "blt_fetch");
      applyStimulus(0, OP_B, 3'b100, 0, 0, 1, 1, decodeV(2'b10, 1'b0), "blt_decode");
      applyStimulus(0, OP_B, 3'b100, 0, 0, 1, 1,
                    ev(4'd9, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001, 0), "blt_branch_taken");

      // bgeu-style funct3 111 with Zero=1 and MSB=1: never taken.
      applyStimulus(0, OP_B, 3'b111, 0, 1, 1, 1, fetchV(2'b10, 1'b1), "b111_fetch");
      applyStimulus(0, OP_B, 3'b111, 0, 1, 1, 1, decodeV(2'b10, 1'b0), "b111_decode");
      applyStimulus(0, OP_B, 3'b111, 0, 1, 1, 1,
                    ev(4'd9, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 3'b001, 0), "b111_branch_not_taken");

      // jal: PC <= target, then rd <= OldPC+4 through ALUWB.
      applyStimulus(0, OP_JAL, 3'b000, 0, 0, 0, 1, fetchV(2'b11, 1'b1), "jal_fetch");
      applyStimulus(0, OP_JAL, 3'b000, 0, 0, 0, 1, decodeV(2'b11, 1'b0), "jal_decode");
      applyStimulus(0, OP_JAL, 3'b000, 0, 0, 0, 1,
                    ev(4'd10, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 0, 3'b000, 0), "jal_jal");
      applyStimulus(0, OP_JAL, 3'b000, 0, 0, 0, 1,
                    ev(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 1, 3'b000, 0), "jal_aluwb");

      // jalr: PC <= rs1+imm, then rd <= OldPC+4.
      applyStimulus(0, OP_JALR, 3'b000, 0, 0, 0, 1, fetchV(2'b00, 1'b1), "jalr_fetch");
      applyStimulus(0, OP_JALR, 3'b000, 0, 0, 0, 1, decodeV(2'b00, 1'b0), "jalr_decode");
      applyStimulus(0, OP_JALR, 3'b000, 0, 0, 0, 1,
                    ev(4'd11, 1, 0, 0, 0, 2'b10, 2'b10, 2'b01, 2'b00, 0, 3'b000, 0), "jalr_jalr");
      applyStimulus(0, OP_JALR, 3'b000, 0, 0, 0, 1,
                    ev(4'd12, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 1, 3'b000, 0), "jalr_jalrwb");

      // sw stalled in MEMWRITE, reset arrives on the second wait cycle.
      applyStimulus(0, OP_SW, 3'b010, 0, 0, 0, 1, fetchV(2'b01, 1'b1), "sw_fetch");
      applyStimulus(0, OP_SW, 3'b010, 0, 0, 0, 1, decodeV(2'b01, 1'b0), "sw_decode");
      applyStimulus(0, OP_SW, 3'b010, 0, 0, 0, 1,
                    ev(4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 0, 3'b000, 0), "sw_memadr");
      applyStimulus(0, OP_SW, 3'b010, 0, 0, 0, 0,
                    ev(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000, 0), "sw_memwrite_wait1");
      applyStimulus(1, OP_SW, 3'b010, 0, 0, 0, 0,
                    ev(4'd5, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0, 3'b000, 0), "sw_memwrite_reset");
      applyStimulus(0, OP_SW, 3'b010, 0, 0, 0, 0, fetchV(2'b01, 1'b0), "sw_after_reset");

      // Unsupported opcode (lui): one-cycle illegal pulse, back to FETCH.
      applyStimulus(0, OP_LUI, 3'b000, 0, 0, 0, 1, fetchV(2'b00, 1'b1), "lui_fetch");
      applyStimulus(0, OP_LUI, 3'b000, 0, 0, 0, 1, decodeV(2'b00, 1'b1), "lui_decode_illegal");
      applyStimulus(0, OP_LUI, 3'b000, 0, 0, 0, 0, fetchV(2'b00, 1'b0), "lui_back_to_fetch");

      // Let the monitor drain, then make sure nothing was left unchecked.
      repeat (2) @(negedge clk);
      checks++;
      if (scoreboard.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending entries expected 0",
                  scoreboard.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
